// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage: word-addressed RAM with fixed access latency,
// stalling the pipeline while an access is in flight and presenting the loaded word.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          aligned;
  logic          accept;
  logic          commit;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_wdata;
  logic          c_wr;

  // Upper address bits fall outside the RAM and are deliberately dropped (address wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW+2];

  always_comb begin
    req        = MemRead_i | MemWrite_i;
    aligned    = (addr_i[1:0] == 2'b00);
    accept     = rst_i && (state == IDLE) && req && aligned;
    stall_o    = accept || (rst_i && (state == BUSY));
    misalign_o = rst_i && (state == IDLE) && req && !aligned;

    // With a single-cycle latency the access commits on the accept edge, straight from the inputs.
    commit  = rst_i && (state == BUSY) && (cnt == CW'(1));
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_wr    = wr_q;
    if (LATENCY == 1) begin
      commit  = accept;
      c_idx   = addr_i[AW+1:2];
      c_wdata = write_data_i;
      c_wr    = MemWrite_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      read_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= write_data_i;
            wr_q    <= MemWrite_i;
            cnt     <= CW'(LATENCY - 1);
            state   <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !c_wr) read_data_o <= mem[c_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && c_wr) mem[c_idx] <= c_wdata;
  end

endmodule
